// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector: loadable N-bit pattern, Mealy match flag,
// selectable overlapping/non-overlapping detection and a saturating match counter.
module seq_detect_param #(
  parameter int             N           = 5,
  parameter logic [N-1:0]   DEFAULT_PAT = N'(5'b11001),
  parameter int             CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             load,
  input  logic [N-1:0]     pattern_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int            FW       = $clog2(N);
  localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);

  logic [N-1:0]  pat;
  logic [N-2:0]  hist;
  logic [FW-1:0] fill;
  logic [N-1:0]  cand;
  logic          hit;

  // fill tracks how many valid bits of hist are real, so stale history
  // after reset/load/non-overlapping hit can never complete a match
  assign cand = {hist, din};
  assign hit  = din_valid & ~load & (fill == FILL_MAX) & (cand == pat);
  assign y    = hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat  <= DEFAULT_PAT;
      hist <= '0;
      fill <= '0;
    end else if (load) begin
      pat  <= pattern_in;
      fill <= '0;
    end else if (din_valid) begin
      hist <= cand[N-2:0];
      if (hit && !overlap)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + FW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      match_cnt <= '0;
    else if (cnt_clr)
      match_cnt <= '0;
    else if (hit && (match_cnt != '1))
      match_cnt <= match_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares y and match_cnt (16-bit and 2-bit counter copies).
module tb_seq_detect_param;

  logic clk, reset, din, din_valid, overlap, load, cnt_clr;
  logic [4:0]  pattern_in;
  logic        y, y2;
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt2;

  typedef struct {
    logic ey;
    int   ec;
    int   ec2;   // -1: narrow counter not checked
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  seq_detect_param #(.N(5), .DEFAULT_PAT(5'b11001), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap(overlap),
    .load(load), .pattern_in(pattern_in), .cnt_clr(cnt_clr), .y(y), .match_cnt(match_cnt)
  );

  seq_detect_param #(.N(5), .DEFAULT_PAT(5'b11001), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .overlap(overlap),
    .load(load), .pattern_in(pattern_in), .cnt_clr(cnt_clr), .y(y2), .match_cnt(match_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", nvec);
    $fatal(1, "watchdog");
  end

  // monitor: one expectation per cycle, checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        nvec++;
        if (y !== e.ey) begin
          nerr++;
          $display("FAIL y vec%0d: got %b want %b", nvec, y, e.ey);
        end
        if (y2 !== e.ey) begin
          nerr++;
          $display("FAIL y_cnt2dut vec%0d: got %b want %b", nvec, y2, e.ey);
        end
        if (int'(match_cnt) != e.ec || $isunknown(match_cnt)) begin
          nerr++;
          $display("FAIL match_cnt vec%0d: got %0d want %0d", nvec, match_cnt, e.ec);
        end
        if (e.ec2 >= 0 && (int'(match_cnt2) != e.ec2 || $isunknown(match_cnt2))) begin
          nerr++;
          $display("FAIL match_cnt_w2 vec%0d: got %0d want %0d", nvec, match_cnt2, e.ec2);
        end
      end
    end
  end

  task automatic drive(input logic d, dv, ld, clr, ey, input int ec, input int ec2);
    exp_t e;
    @(posedge clk);
    #1;
    din = d; din_valid = dv; load = ld; cnt_clr = clr;
    e.ey = ey; e.ec = ec; e.ec2 = ec2;
    q.push_back(e);
  endtask

  task automatic v(input logic d, ey, input int ec, input int ec2 = -1);
    drive(d, 1'b1, 1'b0, 1'b0, ey, ec, ec2);
  endtask

  task automatic gap(input logic d, input int ec, input int ec2 = -1);
    drive(d, 1'b0, 1'b0, 1'b0, 1'b0, ec, ec2);
  endtask

  // reset asserted just after an edge and released before the next one;
  // the check lands with no clock edge in between, so it proves asynchrony
  task automatic rst_pulse();
    exp_t e;
    @(posedge clk);
    #1;
    din = 1'b1; din_valid = 1'b0; load = 1'b0; cnt_clr = 1'b0; reset = 1'b1;
    e.ey = 1'b0; e.ec = 0; e.ec2 = 0;
    q.push_back(e);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; overlap = 1'b1;
    load = 1'b0; cnt_clr = 1'b0; pattern_in = 5'b11001;

    rst_pulse();

    // default pattern, overlapping
    overlap = 1'b1;
    v(1,0,0); v(1,0,0); v(0,0,0); v(0,0,0); v(1,1,0);
    v(1,0,1); v(0,0,1); v(0,0,1); v(1,1,1);
    gap(0,2);

    // non-overlapping: second occurrence sharing bit 5 is not reported
    rst_pulse(); overlap = 1'b0;
    v(1,0,0); v(1,0,0); v(0,0,0); v(0,0,0); v(1,1,0);
    v(1,0,1); v(0,0,1); v(0,0,1); v(1,0,1);
    gap(0,1);
    rst_pulse();
    v(1,0,0); v(1,0,0); v(1,0,0); v(0,0,0); v(0,0,0); v(1,1,0);
    gap(0,1);

    // loaded pattern 10101 (din=1 during load must be ignored)
    rst_pulse(); overlap = 1'b1; pattern_in = 5'b10101;
    drive(1, 1, 1, 0, 0, 0, -1);
    v(1,0,0); v(0,0,0); v(1,0,0); v(0,0,0); v(1,1,0);
    v(0,0,1); v(1,1,1); v(0,0,2); v(1,1,2);
    gap(0,3);
    overlap = 1'b0;
    drive(1, 1, 1, 0, 0, 3, -1);
    v(1,0,3); v(0,0,3); v(1,0,3); v(0,0,3); v(1,1,3);
    v(0,0,4); v(1,0,4); v(0,0,4); v(1,0,4);
    gap(0,4);

    // invalid cycles inside the pattern are skipped
    rst_pulse(); overlap = 1'b1; pattern_in = 5'b11001;
    v(1,0,0); v(1,0,0); v(0,0,0);
    gap(1,0); gap(1,0); gap(1,0);
    v(0,0,0); v(1,1,0);
    gap(0,1);

    // reset mid-stream discards history and clears the counter
    rst_pulse();
    v(1,0,0); v(1,0,0); v(0,0,0); v(0,0,0); v(1,1,0);
    v(1,0,1); v(1,0,1); v(0,0,1); v(0,0,1);
    rst_pulse();
    v(1,0,0);
    v(1,0,0); v(1,0,0); v(0,0,0); v(0,0,0); v(1,1,0);
    gap(0,1);

    // 2-bit counter saturation, then clear coincident with a hit
    rst_pulse();
    v(1,0,0,0); v(1,0,0,0); v(0,0,0,0); v(0,0,0,0); v(1,1,0,0);
    v(1,0,1,1); v(0,0,1,1); v(0,0,1,1); v(1,1,1,1);
    v(1,0,2,2); v(0,0,2,2); v(0,0,2,2); v(1,1,2,2);
    v(1,0,3,3); v(0,0,3,3); v(0,0,3,3); v(1,1,3,3);
    v(1,0,4,3); v(0,0,4,3); v(0,0,4,3); v(1,1,4,3);
    v(1,0,5,3); v(0,0,5,3); v(0,0,5,3);
    drive(1, 1, 0, 1, 1, 5, 3);
    gap(0,0,0);

    @(posedge clk); #1 din_valid = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter N, default 5, pattern length in bits; legal range 2..16.
REQ-002 Parameter DEFAULT_PAT, default 5'b11001, pattern loaded at reset; N bits wide.
REQ-003 Parameter CNT_W, default 16, match counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears state immediately, independent of clk.
REQ-006 din  input  1  serial data bit.
REQ-007 din_valid  input  1  din qualifier; bit consumed only when high.
REQ-008 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
REQ-009 load  input  1  pattern load strobe.
REQ-010 pattern_in  input  N  new pattern; bit N-1 is the first bit received.
REQ-011 cnt_clr  input  1  synchronous match counter clear.
REQ-012 y  output  1  Mealy match flag, combinational from current state and inputs.
REQ-013 match_cnt  output  CNT_W  saturating count of detected matches.

Function
REQ-014 State: pattern register pat[N-1:0], history register hist[N-2:0] (hist[0] newest bit), fill counter fill (0..N-1, saturating at N-1), match_cnt.
REQ-015 Candidate word = {hist[N-2:0], din}; hit = din_valid & ~load & (fill == N-1) & (candidate == pat).
REQ-016 y shall equal hit in the same cycle as the final pattern bit; no registered latency.
REQ-017 On a clock edge with din_valid=1, load=0, no hit: hist shifts left with din entering hist[0]; fill increments, saturating at N-1.
REQ-018 On hit with overlap=1: shift as REQ-017; fill stays N-1.
REQ-019 On hit with overlap=0: shift as REQ-017, then fill becomes 0, so the next match needs N fresh bits.
REQ-020 din_valid=0 (load=0): hist, fill unchanged; y=0.
REQ-021 load=1: pat <= pattern_in, fill <= 0, hist unchanged; din ignored that cycle; y=0. load takes priority over din_valid.
REQ-022 Counter: on hit, match_cnt increments by 1, holding at 2^CNT_W-1 (no wrap).
REQ-023 cnt_clr=1: match_cnt <= 0; cnt_clr wins over a simultaneous hit (result 0). cnt_clr does not affect hist/fill/pat.
REQ-024 overlap change takes effect for any hit in the same cycle; no other state is disturbed.
REQ-025 Behaviour for pattern 11001 shall be identical, bit for bit, to a 5-state overlapping Mealy 11001 detector when overlap=1 and din_valid=1.

Reset
REQ-026 reset=1 asynchronously forces pat=DEFAULT_PAT, hist=0, fill=0, match_cnt=0; y=0 while reset is high.
REQ-027 Reset mid-stream discards partial history; the first match after release needs N new valid bits.
REQ-028 Release of reset takes effect on the first rising clk edge after deassertion; no other warm-up cycles.

Verification
REQ-029 Defaults, overlap=1, din 1,1,0,0,1,1,0,0,1 (valid every cycle) -> y=1 on bits 5 and 9 only; match_cnt=2.
REQ-030 Same stream, overlap=0 -> y=1 on bit 5 only; match_cnt=1. Stream 1,1,1,0,0,1 -> y=1 on bit 6 only.
REQ-031 load with pattern_in=10101, then din 1,0,1,0,1,0,1,0,1 -> overlap=1: y on bits 5,7,9, match_cnt=3; overlap=0: y on bit 5 only.
REQ-032 Defaults, din 1,1,0,0,1 with din_valid low for 3 cycles between bits 3 and 4 -> y=1 only on bit 5; no y during gaps.
REQ-033 After 1,1,0,0, reset pulsed between edges, then 1 -> y stays 0, match_cnt=0; then 1,1,0,0,1 -> y on last bit.
REQ-034 CNT_W=2, 5 matches -> match_cnt reads 1,2,3,3,3; cnt_clr coincident with 6th hit -> match_cnt=0, y=1 that cycle.
